// File: rtl/led_sequencer.sv
// Autonomous LED pattern sequencer: steps a small pattern table into the LED block at a programmable interval.
// Optional build macro LED_SEQUENCER_IRQ_EN adds a sticky DONE flag and the irq output.
module led_sequencer #(
    parameter int unsigned STEPS        = 8,
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write,
    input  logic        cs,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        led_write,
    output logic        led_cs,
    output logic [31:0] led_data,
    output logic        busy
`ifdef LED_SEQUENCER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned IDX_W   = $clog2(STEPS);
    localparam logic [8:0]  STEPS_L = 9'(STEPS);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              step_q, step_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [8:0]              runlen_q, runlen_d;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [7:0]              length_q;
    logic                    loop_q;
    logic [2:0]              entry_q [STEPS];
    logic                    led_write_q, led_write_d;
    logic [2:0]              led_pat_q, led_pat_d;
    logic                    busy_q, busy_d;
    logic                    done_set;
    logic                    done_bit;

    logic             ctrl_wr, per_wr, pat_wr, len_wr;
    logic [IDX_W-1:0] pat_idx, load_idx;
    logic [8:0]       len_eff, limit;
    logic             advance;

    assign ctrl_wr = write & cs & (address == 2'd0);
    assign per_wr  = write & cs & (address == 2'd1);
    assign pat_wr  = write & cs & (address == 2'd2);
    assign len_wr  = write & cs & (address == 2'd3);
    assign pat_idx = data_in[IDX_W-1:0];

    // LENGTH of 0 means one step; anything past the table depth is clamped.
    assign len_eff = (length_q == 8'd0) ? 9'd1 :
                     ({1'b0, length_q} > STEPS_L) ? STEPS_L : {1'b0, length_q};

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and step/counter logic; a CONTROL write overrides everything else.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        runlen_d = runlen_q;
        advance  = 1'b0;
        done_set = 1'b0;
        limit    = (state_q == ST_LOAD) ? len_eff : runlen_q;
        case (state_q)
            ST_LOAD: begin
                runlen_d = len_eff;
                if (period_q > PERIOD_WIDTH'(1)) begin
                    cnt_d   = period_q - PERIOD_WIDTH'(2);
                    state_d = ST_WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) advance = 1'b1;
                else             cnt_d   = cnt_q - PERIOD_WIDTH'(1);
            end
            default: ;
        endcase
        if (advance) begin
            if (({1'b0, step_q} + 9'd1) < limit) begin
                step_d  = step_q + 8'd1;
                state_d = ST_LOAD;
            end else if (loop_q) begin
                step_d  = 8'd0;
                state_d = ST_LOAD;
            end else begin
                state_d  = ST_IDLE;
                done_set = 1'b1;
            end
        end
        if (ctrl_wr) begin
            done_set = 1'b0;
            if (data_in[0]) begin
                step_d  = 8'd0;
                state_d = ST_LOAD;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    assign load_idx = step_d[IDX_W-1:0];

    // Output next-values; a pattern write landing on the entry about to load is forwarded.
    always_comb begin
        led_write_d = (state_d == ST_LOAD);
        busy_d      = (state_d != ST_IDLE);
        led_pat_d   = led_pat_q;
        if (state_d == ST_LOAD) begin
            if (pat_wr && (pat_idx == load_idx)) led_pat_d = data_in[26:24];
            else                                 led_pat_d = entry_q[load_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q      <= 8'd0;
            cnt_q       <= '0;
            runlen_q    <= 9'd0;
            period_q    <= '0;
            length_q    <= 8'd0;
            loop_q      <= 1'b0;
            led_write_q <= 1'b0;
            led_pat_q   <= 3'b000;
            busy_q      <= 1'b0;
            for (int unsigned i = 0; i < STEPS; i++) entry_q[i] <= 3'b111;
        end else begin
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            runlen_q    <= runlen_d;
            led_write_q <= led_write_d;
            led_pat_q   <= led_pat_d;
            busy_q      <= busy_d;
            if (per_wr)  period_q         <= data_in[PERIOD_WIDTH-1:0];
            if (len_wr)  length_q         <= data_in[7:0];
            if (ctrl_wr) loop_q           <= data_in[1];
            if (pat_wr)  entry_q[pat_idx] <= data_in[26:24];
        end
    end

`ifdef LED_SEQUENCER_IRQ_EN
    logic done_q;
    logic unused_bits;

    // Sticky completion flag; an explicit clear beats a same-cycle set.
    always_ff @(posedge clock) begin
        if (reset)                      done_q <= 1'b0;
        else if (ctrl_wr && data_in[31]) done_q <= 1'b0;
        else if (done_set)              done_q <= 1'b1;
    end

    assign irq         = done_q;
    assign done_bit    = done_q;
    assign unused_bits = ^data_in;
`else
    logic unused_bits;
    assign done_bit    = 1'b0;
    assign unused_bits = ^{data_in, done_set};
`endif

    assign led_write = led_write_q;
    assign led_cs    = led_write_q;
    assign led_data  = {5'b0, led_pat_q, 24'b0};
    assign busy      = busy_q;

    always_comb begin
        data_out = 32'd0;
        case (address)
            2'd0: data_out = {16'b0, step_q, 5'b0, done_bit, loop_q, busy_q};
            2'd1: data_out = 32'(period_q);
            2'd2: data_out = {5'b0, entry_q[0], 24'b0};
            2'd3: data_out = {24'b0, length_q};
            default: data_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer; irq checks enabled with LED_SEQUENCER_IRQ_EN.
module tb_led_sequencer;

    logic        clock;
    logic        reset;
    logic        write;
    logic        cs;
    logic [1:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        led_write;
    logic        led_cs;
    logic [31:0] led_data;
    logic        busy;
`ifdef LED_SEQUENCER_IRQ_EN
    logic        irq;
`endif

    int total;
    int bad;

    led_sequencer #(.STEPS(8), .PERIOD_WIDTH(24)) dut (
        .clock    (clock),
        .reset    (reset),
        .write    (write),
        .cs       (cs),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .led_write(led_write),
        .led_cs   (led_cs),
        .led_data (led_data),
        .busy     (busy)
`ifdef LED_SEQUENCER_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        write   = 1'b1;
        cs      = 1'b1;
        address = a;
        data_in = d;
        tick();
        write   = 1'b0;
        cs      = 1'b0;
        data_in = 32'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (led_write !== 1'b0) begin bad++; $display("FAIL reset_led_write got=%b want=0", led_write); end
        total++; if (led_cs !== 1'b0) begin bad++; $display("FAIL reset_led_cs got=%b want=0", led_cs); end
        total++; if (led_data !== 32'd0) begin bad++; $display("FAIL reset_led_data got=%h want=0", led_data); end
        address = 2'd2; #1;
        total++; if (data_out !== 32'h0700_0000) begin bad++; $display("FAIL reset_entry0 got=%h want=07000000", data_out); end
        address = 2'd0; #1;
        total++; if (data_out !== 32'd0) begin bad++; $display("FAIL reset_control got=%h want=0", data_out); end
        address = 2'd1; #1;
        total++; if (data_out !== 32'd0) begin bad++; $display("FAIL reset_period got=%h want=0", data_out); end
`ifdef LED_SEQUENCER_IRQ_EN
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
`endif
    endtask

    task automatic test_single_run;
        logic [31:0] exp_d;
        logic        pulse;
        logic [31:0] exp_ctl;
        int          pat [3] = '{1, 2, 4};
        bus_write(2'd2, 32'h0100_0000);
        bus_write(2'd2, 32'h0200_0001);
        bus_write(2'd2, 32'h0400_0002);
        bus_write(2'd1, 32'd5);
        bus_write(2'd3, 32'd3);
        bus_write(2'd0, 32'h1);
        exp_d = 32'd0;
        for (int i = 0; i < 20; i++) begin
            pulse = (i % 5 == 0) && (i < 15);
            if (pulse) exp_d = 32'(pat[i / 5]) << 24;
            total++; if (led_write !== pulse) begin bad++; $display("FAIL single_led_write cyc=%0d got=%b want=%b", i, led_write, pulse); end
            total++; if (led_cs !== pulse) begin bad++; $display("FAIL single_led_cs cyc=%0d got=%b want=%b", i, led_cs, pulse); end
            total++; if (led_data !== exp_d) begin bad++; $display("FAIL single_led_data cyc=%0d got=%h want=%h", i, led_data, exp_d); end
            total++; if (busy !== (i < 15)) begin bad++; $display("FAIL single_busy cyc=%0d got=%b want=%b", i, busy, (i < 15)); end
            tick();
        end
        exp_ctl = 32'h0000_0200;
`ifdef LED_SEQUENCER_IRQ_EN
        exp_ctl = 32'h0000_0204;
`endif
        address = 2'd0; #1;
        total++; if (data_out !== exp_ctl) begin bad++; $display("FAIL single_control got=%h want=%h", data_out, exp_ctl); end
        address = 2'd1; #1;
        total++; if (data_out !== 32'd5) begin bad++; $display("FAIL single_period got=%h want=5", data_out); end
    endtask

    task automatic test_loop_stop;
        logic [31:0] exp_d;
        bus_write(2'd1, 32'd1);
        bus_write(2'd3, 32'd2);
        bus_write(2'd0, 32'h3);
        for (int i = 0; i < 7; i++) begin
            exp_d = (i % 2 == 0) ? 32'h0100_0000 : 32'h0200_0000;
            total++; if (led_write !== 1'b1) begin bad++; $display("FAIL loop_led_write cyc=%0d got=%b want=1", i, led_write); end
            total++; if (led_data !== exp_d) begin bad++; $display("FAIL loop_led_data cyc=%0d got=%h want=%h", i, led_data, exp_d); end
            if (i < 6) tick();
        end
        bus_write(2'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            total++; if (led_write !== 1'b0) begin bad++; $display("FAIL stop_led_write cyc=%0d got=%b want=0", k, led_write); end
            total++; if (led_data !== 32'h0100_0000) begin bad++; $display("FAIL stop_led_hold cyc=%0d got=%h want=01000000", k, led_data); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy cyc=%0d got=%b want=0", k, busy); end
            tick();
        end
        address = 2'd0; #1;
        total++; if (data_out[1:0] !== 2'b00) begin bad++; $display("FAIL stop_control got=%b want=00", data_out[1:0]); end
    endtask

    task automatic test_zero_clamp;
        logic [31:0] exp_d;
        logic        pulse;
        int          pat [8] = '{1, 2, 4, 3, 5, 6, 7, 0};
        bus_write(2'd1, 32'd0);
        bus_write(2'd3, 32'd0);
        bus_write(2'd0, 32'h1);
        total++; if (led_write !== 1'b1 || led_data !== 32'h0100_0000) begin bad++; $display("FAIL zero_pulse got=%b/%h want=1/01000000", led_write, led_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_on got=%b want=1", busy); end
        tick();
        total++; if (led_write !== 1'b0) begin bad++; $display("FAIL zero_single got=%b want=0", led_write); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_off got=%b want=0", busy); end
        // index 0x0B wraps to entry 3
        bus_write(2'd2, 32'h0300_000B);
        bus_write(2'd2, 32'h0500_0004);
        bus_write(2'd2, 32'h0600_0005);
        bus_write(2'd2, 32'h0700_0006);
        bus_write(2'd2, 32'h0000_0007);
        bus_write(2'd3, 32'd20);
        address = 2'd3; #1;
        total++; if (data_out !== 32'd20) begin bad++; $display("FAIL clamp_length_read got=%h want=14", data_out); end
        bus_write(2'd0, 32'h1);
        exp_d = 32'd0;
        for (int i = 0; i < 10; i++) begin
            pulse = (i < 8);
            if (pulse) exp_d = 32'(pat[i]) << 24;
            total++; if (led_write !== pulse) begin bad++; $display("FAIL clamp_led_write cyc=%0d got=%b want=%b", i, led_write, pulse); end
            total++; if (led_data !== exp_d) begin bad++; $display("FAIL clamp_led_data cyc=%0d got=%h want=%h", i, led_data, exp_d); end
            total++; if (busy !== pulse) begin bad++; $display("FAIL clamp_busy cyc=%0d got=%b want=%b", i, busy, pulse); end
            tick();
        end
    endtask

    task automatic test_restart;
        logic [31:0] exp_d;
        logic        pulse;
        int          pat [3] = '{1, 2, 4};
        bus_write(2'd1, 32'd3);
        bus_write(2'd3, 32'd8);
        bus_write(2'd0, 32'h1);
        exp_d = 32'd0;
        for (int i = 0; i < 7; i++) begin
            pulse = (i % 3 == 0);
            if (pulse) exp_d = 32'(pat[i / 3]) << 24;
            total++; if (led_write !== pulse) begin bad++; $display("FAIL restart_pre_write cyc=%0d got=%b want=%b", i, led_write, pulse); end
            total++; if (led_data !== exp_d) begin bad++; $display("FAIL restart_pre_data cyc=%0d got=%h want=%h", i, led_data, exp_d); end
            if (i < 6) tick();
        end
        bus_write(2'd0, 32'h1);
        for (int j = 0; j < 4; j++) begin
            pulse = (j == 0) || (j == 3);
            exp_d = (j == 3) ? 32'h0200_0000 : 32'h0100_0000;
            total++; if (led_write !== pulse) begin bad++; $display("FAIL restart_write cyc=%0d got=%b want=%b", j, led_write, pulse); end
            total++; if (led_data !== exp_d) begin bad++; $display("FAIL restart_data cyc=%0d got=%h want=%h", j, led_data, exp_d); end
            tick();
        end
        bus_write(2'd0, 32'h0);
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_stop_busy got=%b want=0", busy); end
    endtask

`ifdef LED_SEQUENCER_IRQ_EN
    task automatic test_irq;
        bus_write(2'd0, 32'h8000_0000);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear0 got=%b want=0", irq); end
        bus_write(2'd1, 32'd1);
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'h1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_during_run got=%b want=0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want=1", irq); end
        address = 2'd0; #1;
        total++; if (data_out[2] !== 1'b1) begin bad++; $display("FAIL irq_done_read got=%b want=1", data_out[2]); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_sticky got=%b want=1", irq); end
        bus_write(2'd0, 32'h8000_0000);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b want=0", irq); end
    endtask
`endif

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        write   = 1'b0;
        cs      = 1'b0;
        address = 2'd0;
        data_in = 32'd0;
        test_reset();
        test_single_run();
        test_loop_stop();
        test_zero_clamp();
        test_restart();
`ifdef LED_SEQUENCER_IRQ_EN
        test_irq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
